core_trace_buf: RTL and testbench

Parametrised register-writeback trace buffer for the darksocv core, successor to the flat monitor signal bundle. It captures each writeback event into a circular buffer: destination pointer, result data, both source operands and a cycle timestamp. The event is armed and gated by a small capture FSM. The testbench monitor or a debug port drains the buffer through a valid/ready interface. It sits beside the core, fed from the same DPTR/S1REG/S2REG/result nets the monitor taps.

---
 rtl/core_trace_buf.sv | 176 +++++++++++++++++
 tb/tb_core_trace_buf.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/core_trace_buf.sv
// Writeback trace buffer: captures DPTR/result/operands/timestamp into a circular FIFO drained via valid/ready.
// Optional feature macro TRACE_TRIG_EN adds an ARMED state that waits for the first writeback to trig_dptr.
module core_trace_buf #(
    parameter int DATA_W    = 32,
    parameter int PTR_W     = 5,
    parameter int DEPTH     = 16,
    parameter int TS_W      = 16,
    parameter int WRAP_MODE = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     cap_en,
    input  logic [PTR_W-1:0]         trig_dptr,
    input  logic                     wb_valid,
    input  logic [PTR_W-1:0]         wb_dptr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic [DATA_W-1:0]        wb_s1reg,
    input  logic [DATA_W-1:0]        wb_s2reg,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [PTR_W-1:0]         rd_dptr,
    output logic [DATA_W-1:0]        rd_data,
    output logic [DATA_W-1:0]        rd_s1,
    output logic [DATA_W-1:0]        rd_s2,
    output logic [TS_W-1:0]          rd_ts,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic [15:0]              drop_cnt,
    output logic [1:0]               state
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    head_q, head_d;
    logic [AW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [15:0]      dropCnt_q, dropCnt_d;
    logic [TS_W-1:0]  ts_q;

    logic [PTR_W-1:0]  memDptr_q [DEPTH];
    logic [DATA_W-1:0] memData_q [DEPTH];
    logic [DATA_W-1:0] memS1_q   [DEPTH];
    logic [DATA_W-1:0] memS2_q   [DEPTH];
    logic [TS_W-1:0]   memTs_q   [DEPTH];

    logic trigHit;
    logic push;
    logic popFire;
    logic isFull;
    logic isEmpty;
    logic wrEn;

    assign trigHit = wb_valid && (wb_dptr == trig_dptr);
    assign isFull  = (count_q == FULL_CNT);
    assign isEmpty = (count_q == '0);
    assign popFire = rd_ready && !isEmpty;

    // The triggering writeback is itself captured; a cycle that drops cap_en captures nothing.
    assign push = !clear && cap_en && wb_valid &&
                  ((state_q == RUN) || ((state_q == ARMED) && trigHit));

    always_comb begin
        state_d = state_q;
        if (!clear) begin
            case (state_q)
                IDLE: begin
                    if (cap_en) begin
`ifdef TRACE_TRIG_EN
                        state_d = ARMED;
`else
                        state_d = RUN;
`endif
                    end
                end
                ARMED: begin
                    if (!cap_en)
                        state_d = IDLE;
                    else if (trigHit)
                        state_d = RUN;
                end
                RUN: begin
                    if (!cap_en)
                        state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        dropCnt_d = dropCnt_q;
        wrEn      = 1'b0;
        if (clear) begin
            head_d    = '0;
            tail_d    = '0;
            count_d   = '0;
            dropCnt_d = '0;
        end else if (push && popFire) begin
            wrEn   = 1'b1;
            tail_d = tail_q + 1'b1;
            head_d = head_q + 1'b1;
        end else if (push && !isFull) begin
            wrEn    = 1'b1;
            tail_d  = tail_q + 1'b1;
            count_d = count_q + 1'b1;
        end else if (push) begin
            // Full with no pop: overwrite mode slides the window, stop mode discards the newest.
            if (WRAP_MODE != 0) begin
                wrEn   = 1'b1;
                tail_d = tail_q + 1'b1;
                head_d = head_q + 1'b1;
            end
            if (dropCnt_q != 16'hFFFF)
                dropCnt_d = dropCnt_q + 16'd1;
        end else if (popFire) begin
            head_d  = head_q + 1'b1;
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            dropCnt_q <= '0;
            ts_q      <= '0;
        end else begin
            state_q   <= state_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            dropCnt_q <= dropCnt_d;
            ts_q      <= ts_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && wrEn) begin
            memDptr_q[tail_q] <= wb_dptr;
            memData_q[tail_q] <= wb_data;
            memS1_q[tail_q]   <= wb_s1reg;
            memS2_q[tail_q]   <= wb_s2reg;
            memTs_q[tail_q]   <= ts_q;
        end
    end

    // Storage is not reset, so the head fields are masked to zero while the buffer is empty.
    assign rd_valid = !isEmpty;
    assign rd_dptr  = isEmpty ? '0 : memDptr_q[head_q];
    assign rd_data  = isEmpty ? '0 : memData_q[head_q];
    assign rd_s1    = isEmpty ? '0 : memS1_q[head_q];
    assign rd_s2    = isEmpty ? '0 : memS2_q[head_q];
    assign rd_ts    = isEmpty ? '0 : memTs_q[head_q];
    assign count    = count_q;
    assign full     = isFull;
    assign empty    = isEmpty;
    assign drop_cnt = dropCnt_q;
    assign state    = state_q;

endmodule

// File: tb/tb_core_trace_buf.sv
// Directed bench for core_trace_buf: two instances (stop mode and overwrite mode) share stimulus.
module tb_core_trace_buf;

    logic        clk = 1'b0;
    logic        rst_n, clear, cap_en, wb_valid;
    logic [4:0]  trig_dptr, wb_dptr;
    logic [31:0] wb_data, wb_s1reg, wb_s2reg;
    logic        rdReady0, rdReady1;

    logic        rdValid0, full0, empty0;
    logic [4:0]  rdDptr0, count0;
    logic [31:0] rdData0, rdS10, rdS20;
    logic [15:0] rdTs0, drop0;
    logic [1:0]  state0;

    logic        rdValid1, full1, empty1;
    logic [4:0]  rdDptr1, count1;
    logic [31:0] rdData1, rdS11, rdS21;
    logic [15:0] rdTs1, drop1;
    logic [1:0]  state1;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] tbTs = '0;
    logic [15:0] lastTs;
    logic [15:0] tsExp [3];

    core_trace_buf #(.WRAP_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .cap_en(cap_en), .trig_dptr(trig_dptr),
        .wb_valid(wb_valid), .wb_dptr(wb_dptr), .wb_data(wb_data), .wb_s1reg(wb_s1reg), .wb_s2reg(wb_s2reg),
        .rd_valid(rdValid0), .rd_ready(rdReady0), .rd_dptr(rdDptr0), .rd_data(rdData0), .rd_s1(rdS10),
        .rd_s2(rdS20), .rd_ts(rdTs0), .count(count0), .full(full0), .empty(empty0), .drop_cnt(drop0),
        .state(state0)
    );

    core_trace_buf #(.WRAP_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .cap_en(cap_en), .trig_dptr(trig_dptr),
        .wb_valid(wb_valid), .wb_dptr(wb_dptr), .wb_data(wb_data), .wb_s1reg(wb_s1reg), .wb_s2reg(wb_s2reg),
        .rd_valid(rdValid1), .rd_ready(rdReady1), .rd_dptr(rdDptr1), .rd_data(rdData1), .rd_s1(rdS11),
        .rd_s2(rdS21), .rd_ts(rdTs1), .count(count1), .full(full1), .empty(empty1), .drop_cnt(drop1),
        .state(state1)
    );

    always #5 clk = ~clk;

    // Reference timestamp: zeroed by a reset edge, otherwise one step per rising edge.
    always @(posedge clk) tbTs <= rst_n ? tbTs + 16'd1 : 16'd0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_n = 1'b0; clear = 1'b0; cap_en = 1'b0; wb_valid = 1'b0;
        wb_dptr = '0; wb_data = '0; wb_s1reg = '0; wb_s2reg = '0;
        rdReady0 = 1'b0; rdReady1 = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    // One writeback event in the next cycle; records the timestamp it should carry.
    task automatic applyStimulus(input logic [4:0] dptr, input logic [31:0] data);
        wb_valid = 1'b1;
        wb_dptr  = dptr;
        wb_data  = data;
        wb_s1reg = data ^ 32'hA5A5_0000;
        wb_s2reg = data + 32'd1;
        lastTs   = tbTs;
        step();
        wb_valid = 1'b0;
    endtask

    task automatic startCapture();
        cap_en = 1'b1;
        step();
`ifdef TRACE_TRIG_EN
        applyStimulus(trig_dptr, 32'hDEAD_0000);
        clear = 1'b1;
        step();
        clear = 1'b0;
`endif
    endtask

    task automatic test_reset();
        doReset();
        checks++; if (count0 !== 5'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", count0); end
        checks++; if (empty0 !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty: got %b expected 1", empty0); end
        checks++; if (full0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_full: got %b expected 0", full0); end
        checks++; if (rdValid0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_valid: got %b expected 0", rdValid0); end
        checks++; if (drop0 !== 16'd0) begin errors++; $display("[TB] FAIL reset_drop: got %0d expected 0", drop0); end
        checks++; if (state0 !== 2'd0) begin errors++; $display("[TB] FAIL reset_state: got %0d expected 0", state0); end
        checks++; if (rdData0 !== 32'd0) begin errors++; $display("[TB] FAIL reset_rd_data: got %h expected 0", rdData0); end
    endtask

    task automatic test_basic_capture();
        logic [4:0]  expD [3];
        logic [31:0] expV [3];
        expD[0] = 5'd1; expD[1] = 5'd2; expD[2] = 5'd3;
        expV[0] = 32'h11; expV[1] = 32'h22; expV[2] = 32'h33;
        doReset();
        startCapture();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(expD[i], expV[i]);
            tsExp[i] = lastTs;
        end
        checks++; if (count0 !== 5'd3) begin errors++; $display("[TB] FAIL basic_count: got %0d expected 3", count0); end
        checks++; if (rdS10 !== (32'h11 ^ 32'hA5A5_0000)) begin errors++; $display("[TB] FAIL basic_s1: got %h expected %h", rdS10, 32'h11 ^ 32'hA5A5_0000); end
        checks++; if (rdS20 !== 32'h12) begin errors++; $display("[TB] FAIL basic_s2: got %h expected 12", rdS20); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (rdDptr0 !== expD[i]) begin errors++; $display("[TB] FAIL basic_dptr%0d: got %0d expected %0d", i, rdDptr0, expD[i]); end
            checks++; if (rdData0 !== expV[i]) begin errors++; $display("[TB] FAIL basic_data%0d: got %h expected %h", i, rdData0, expV[i]); end
            checks++; if (rdTs0 !== tsExp[i]) begin errors++; $display("[TB] FAIL basic_ts%0d: got %0d expected %0d", i, rdTs0, tsExp[i]); end
            rdReady0 = 1'b1;
            step();
        end
        rdReady0 = 1'b0;
        checks++; if (empty0 !== 1'b1) begin errors++; $display("[TB] FAIL basic_empty_after: got %b expected 1", empty0); end
        checks++; if (count0 !== 5'd0) begin errors++; $display("[TB] FAIL basic_count_after: got %0d expected 0", count0); end
    endtask

    task automatic test_overflow();
        doReset();
        startCapture();
        for (int i = 0; i < 20; i++) applyStimulus(5'(i), 32'h1000 + 32'(i));
        checks++; if (count0 !== 5'd16) begin errors++; $display("[TB] FAIL stop_count: got %0d expected 16", count0); end
        checks++; if (full0 !== 1'b1) begin errors++; $display("[TB] FAIL stop_full: got %b expected 1", full0); end
        checks++; if (drop0 !== 16'd4) begin errors++; $display("[TB] FAIL stop_drop: got %0d expected 4", drop0); end
        checks++; if (count1 !== 5'd16) begin errors++; $display("[TB] FAIL wrap_count: got %0d expected 16", count1); end
        checks++; if (full1 !== 1'b1) begin errors++; $display("[TB] FAIL wrap_full: got %b expected 1", full1); end
        checks++; if (drop1 !== 16'd4) begin errors++; $display("[TB] FAIL wrap_drop: got %0d expected 4", drop1); end
        cap_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            checks++; if (rdData0 !== 32'h1000 + 32'(i)) begin errors++; $display("[TB] FAIL stop_read%0d: got %h expected %h", i, rdData0, 32'h1000 + 32'(i)); end
            checks++; if (rdData1 !== 32'h1004 + 32'(i)) begin errors++; $display("[TB] FAIL wrap_read%0d: got %h expected %h", i, rdData1, 32'h1004 + 32'(i)); end
            rdReady0 = 1'b1; rdReady1 = 1'b1;
            step();
        end
        rdReady0 = 1'b0; rdReady1 = 1'b0;
        checks++; if (empty0 !== 1'b1 || empty1 !== 1'b1) begin errors++; $display("[TB] FAIL overflow_drained: got %b%b expected 11", empty0, empty1); end
    endtask

    task automatic test_full_push_pop();
        doReset();
        startCapture();
        for (int i = 0; i < 16; i++) applyStimulus(5'(i), 32'h2000 + 32'(i));
        checks++; if (rdData0 !== 32'h2000 || rdData1 !== 32'h2000) begin errors++; $display("[TB] FAIL pp_oldest: got %h/%h expected 2000", rdData0, rdData1); end
        rdReady0 = 1'b1; rdReady1 = 1'b1;
        applyStimulus(5'd16, 32'h2010);
        rdReady0 = 1'b0; rdReady1 = 1'b0;
        checks++; if (count0 !== 5'd16 || count1 !== 5'd16) begin errors++; $display("[TB] FAIL pp_count: got %0d/%0d expected 16", count0, count1); end
        checks++; if (drop0 !== 16'd0 || drop1 !== 16'd0) begin errors++; $display("[TB] FAIL pp_drop: got %0d/%0d expected 0", drop0, drop1); end
        checks++; if (rdData0 !== 32'h2001 || rdData1 !== 32'h2001) begin errors++; $display("[TB] FAIL pp_next_head: got %h/%h expected 2001", rdData0, rdData1); end
    endtask

    task automatic test_trigger();
        doReset();
        trig_dptr = 5'd10;
        cap_en = 1'b1;
        step();
`ifdef TRACE_TRIG_EN
        checks++; if (state0 !== 2'd1) begin errors++; $display("[TB] FAIL trig_armed: got %0d expected 1", state0); end
`else
        checks++; if (state0 !== 2'd2) begin errors++; $display("[TB] FAIL trig_run_direct: got %0d expected 2", state0); end
`endif
        applyStimulus(5'd5, 32'h55);
        applyStimulus(5'd7, 32'h77);
        applyStimulus(5'd10, 32'hAA);
        applyStimulus(5'd11, 32'hBB);
        checks++; if (state0 !== 2'd2) begin errors++; $display("[TB] FAIL trig_run: got %0d expected 2", state0); end
`ifdef TRACE_TRIG_EN
        checks++; if (count0 !== 5'd2) begin errors++; $display("[TB] FAIL trig_count: got %0d expected 2", count0); end
        checks++; if (rdDptr0 !== 5'd10) begin errors++; $display("[TB] FAIL trig_head: got %0d expected 10", rdDptr0); end
`else
        checks++; if (count0 !== 5'd4) begin errors++; $display("[TB] FAIL trig_count: got %0d expected 4", count0); end
        checks++; if (rdDptr0 !== 5'd5) begin errors++; $display("[TB] FAIL trig_head: got %0d expected 5", rdDptr0); end
`endif
        cap_en = 1'b0;
        applyStimulus(5'd12, 32'hCC);
        checks++; if (state0 !== 2'd0) begin errors++; $display("[TB] FAIL stop_idle: got %0d expected 0", state0); end
`ifdef TRACE_TRIG_EN
        checks++; if (count0 !== 5'd2) begin errors++; $display("[TB] FAIL stop_no_capture: got %0d expected 2", count0); end
`else
        checks++; if (count0 !== 5'd4) begin errors++; $display("[TB] FAIL stop_no_capture: got %0d expected 4", count0); end
`endif
    endtask

    task automatic test_clear();
        doReset();
        startCapture();
        for (int i = 0; i < 18; i++) applyStimulus(5'(i), 32'h3000 + 32'(i));
        rdReady0 = 1'b1;
        repeat (11) step();
        rdReady0 = 1'b0;
        checks++; if (count0 !== 5'd5 || drop0 !== 16'd2) begin errors++; $display("[TB] FAIL clear_setup: got count %0d drop %0d expected 5/2", count0, drop0); end
        clear = 1'b1;
        applyStimulus(5'd1, 32'h3100);
        clear = 1'b0;
        checks++; if (count0 !== 5'd0) begin errors++; $display("[TB] FAIL clear_count: got %0d expected 0", count0); end
        checks++; if (drop0 !== 16'd0) begin errors++; $display("[TB] FAIL clear_drop: got %0d expected 0", drop0); end
        checks++; if (empty0 !== 1'b1 || rdValid0 !== 1'b0) begin errors++; $display("[TB] FAIL clear_empty: got %b/%b expected 1/0", empty0, rdValid0); end
        checks++; if (state0 !== 2'd2) begin errors++; $display("[TB] FAIL clear_state: got %0d expected 2", state0); end
    endtask

    task automatic test_reset_midburst();
        doReset();
        startCapture();
        for (int i = 0; i < 4; i++) applyStimulus(5'(i), 32'h4000 + 32'(i));
        rst_n = 1'b0;
        rdReady0 = 1'b1;
        applyStimulus(5'd9, 32'h4009);
        rst_n = 1'b1;
        rdReady0 = 1'b0;
        checks++; if (count0 !== 5'd0 || empty0 !== 1'b1 || rdValid0 !== 1'b0) begin errors++; $display("[TB] FAIL midrst_occ: got count %0d empty %b valid %b expected 0/1/0", count0, empty0, rdValid0); end
        checks++; if (state0 !== 2'd0 || drop0 !== 16'd0) begin errors++; $display("[TB] FAIL midrst_state: got state %0d drop %0d expected 0/0", state0, drop0); end
        checks++; if (rdData0 !== 32'd0 || rdTs0 !== 16'd0 || rdDptr0 !== 5'd0) begin errors++; $display("[TB] FAIL midrst_fields: got %h/%h/%h expected zeros", rdData0, rdTs0, rdDptr0); end
        startCapture();
        applyStimulus(5'd3, 32'h4100);
        checks++; if (rdTs0 !== lastTs) begin errors++; $display("[TB] FAIL midrst_ts: got %0d expected %0d", rdTs0, lastTs); end
    endtask

    initial begin
        trig_dptr = 5'd0;
        test_reset();
        test_basic_capture();
        test_overflow();
        test_full_push_pop();
        test_trigger();
        test_clear();
        test_reset_midburst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
